// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LUT layer: one shared truth-table read per cycle evaluates
// NUM_NEURONS neurons in sequence, then presents the packed result vector.
module lut_layer_scheduler #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned IN_BITS     = 8,
  parameter int unsigned OUT_BITS    = 2,
  localparam int unsigned NIDX_W     = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_NEURONS*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic [NIDX_W-1:0]               cfg_neuron,
  input  logic [IN_BITS-1:0]              cfg_addr,
  input  logic [OUT_BITS-1:0]             cfg_data,
  output logic                            cfg_ready,
  output logic                            busy
);

  // Table is flattened as {neuron, entry}; neuron indices stay below
  // NUM_NEURONS so every reachable address is inside the array.
  localparam int unsigned Depth = NUM_NEURONS * (2 ** IN_BITS);
  localparam int unsigned AddrW = NIDX_W + IN_BITS;
  localparam int unsigned LastIdx = NUM_NEURONS - 1;

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  state_e state_q, state_d;

  logic [NIDX_W-1:0]               idx_q;
  logic [NUM_NEURONS*IN_BITS-1:0]  in_reg_q;
  logic [NUM_NEURONS*OUT_BITS-1:0] result_q;
  logic [OUT_BITS-1:0]             lut_mem [Depth];

  logic [IN_BITS-1:0]  rd_slice;
  logic [AddrW-1:0]    rd_addr;
  logic [AddrW-1:0]    wr_addr;
  logic [OUT_BITS-1:0] rd_data;
  logic                wr_en;
  logic                accept;
  logic                last_idx;
  logic                neuron_ok;

  assign neuron_ok = ({1'b0, cfg_neuron} < (NIDX_W + 1)'(NUM_NEURONS));
  assign wr_en     = cfg_we && cfg_ready && neuron_ok && !rst;
  assign wr_addr   = {cfg_neuron, cfg_addr};
  assign rd_slice  = in_reg_q[idx_q*IN_BITS +: IN_BITS];
  assign rd_addr   = {idx_q, rd_slice};
  assign rd_data   = lut_mem[rd_addr];
  assign accept    = in_valid && in_ready;
  assign last_idx  = (idx_q == NIDX_W'(LastIdx));

  // Truth-table write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lut_mem[wr_addr] <= cfg_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StEval;
      StEval:  if (last_idx) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state.
  always_comb begin
    in_ready  = 1'b0;
    cfg_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready  = 1'b1;
        cfg_ready = 1'b1;
      end
      StEval:  busy = 1'b1;
      StDone: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture input on accept, fill one result slice per EVAL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      in_reg_q <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            in_reg_q <= in_data;
            idx_q    <= '0;
          end
        end
        StEval: begin
          result_q[idx_q*OUT_BITS +: OUT_BITS] <= rd_data;
          idx_q <= last_idx ? '0 : idx_q + NIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_data = result_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Scoreboard bench for lut_layer_scheduler (NUM_NEURONS=4, IN_BITS=8, OUT_BITS=2).
module tb_lut_layer_scheduler;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [7:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_ready;
  logic        busy;

  lut_layer_scheduler #(
    .NUM_NEURONS(4),
    .IN_BITS    (8),
    .OUT_BITS   (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .cfg_we    (cfg_we),
    .cfg_neuron(cfg_neuron),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [1:0] ref_tbl [4][256];
  logic [7:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: each neuron looks up its own byte of the input in its own table.
  function automatic logic [7:0] model_eval(input logic [31:0] d);
    logic [7:0] r;
    for (int i = 0; i < 4; i++) r[i*2 +: 2] = ref_tbl[i][d[i*8 +: 8]];
    return r;
  endfunction

  // Monitor: the result is consumed at the next edge whenever valid and ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %h expected none", out_data);
      end else begin
        chk("sb_data", {24'h0, out_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int unsigned n, input int unsigned a, input int unsigned d);
    cfg_we     = 1'b1;
    cfg_neuron = 2'(n);
    cfg_addr   = 8'(a);
    cfg_data   = 2'(d);
    ref_tbl[n][a] = 2'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit with_cfg,
                      input int unsigned cn, input int unsigned ca, input int unsigned cd);
    int g = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && g < 50) begin
      step();
      g++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    if (with_cfg) begin
      cfg_we     = 1'b1;
      cfg_neuron = 2'(cn);
      cfg_addr   = 8'(ca);
      cfg_data   = 2'(cd);
      ref_tbl[cn][ca] = 2'(cd);
    end
    sb.push_back(model_eval(d));
    step();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while ((busy || sb.size() != 0) && g < 50) begin
      step();
      g++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic stream(input int n);
    int acc[$];
    int got = 0;
    int guard = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = $urandom;
    while (got < n && guard < 200) begin
      if (in_ready) begin
        sb.push_back(model_eval(in_data));
        acc.push_back(cyc);
        got++;
        step();
        in_data = $urandom;
      end else begin
        step();
      end
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_count", got, n);
    for (int i = 1; i < acc.size(); i++) chk("stream_period", acc[i] - acc[i-1], 6);
  endtask

  task automatic rand_txn();
    int n = 0;
    bit done = 0;
    send($urandom, 1'b0, 0, 0, 0);
    while (!done && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) done = 1;
      step();
      n++;
    end
    chk("rand_handshake", {31'h0, done}, 32'h1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    cfg_we     = 1'b0;
    cfg_neuron = '0;
    cfg_addr   = '0;
    cfg_data   = '0;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_state", {27'h0, in_ready, cfg_ready, out_valid, busy, 1'b0}, {27'h0, 5'b11000});
    chk("rst_out_data", {24'h0, out_data}, 32'h0);

    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 256; a++)
        cfg_write(i, a, (i == 0 && a == 'h5A) ? 3 : 0);

    // Latency and DONE hold with out_ready low.
    out_ready = 1'b0;
    send(32'h5A5A5A5A, 1'b0, 0, 0, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("latency", n, 4);
    for (int k = 0; k < 5; k++) begin
      chk("done_hold", {20'h0, out_valid, in_ready, cfg_ready, busy, out_data},
          {20'h0, 4'b1001, 8'h03});
      step();
    end
    out_ready = 1'b1;
    step();
    chk("post_hs", {28'h0, out_valid, in_ready, cfg_ready, busy}, {28'h0, 4'b0110});
    chk("idle_hold", {24'h0, out_data}, 32'h03);

    // Reset mid-EVAL aborts; rerun gives the original result.
    send(32'h5A5A5A5A, 1'b0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_abort", {22'h0, out_valid, in_ready, out_data}, {22'h0, 2'b01, 8'h00});
    sb.delete();
    send(32'h5A5A5A5A, 1'b0, 0, 0, 0);
    drain();
    chk("rerun", {24'h0, out_data}, 32'h03);

    // Same-cycle cfg write is seen by the evaluation it coincides with.
    send(32'h01000000, 1'b1, 3, 1, 2);
    drain();
    chk("cfg_same_cycle", {24'h0, out_data}, 32'h80);

    // Writes during EVAL are dropped.
    send(32'h00000000, 1'b0, 0, 0, 0);
    chk("cfg_ready_eval", {31'h0, cfg_ready}, 32'h0);
    cfg_we     = 1'b1;
    cfg_neuron = 2'd1;
    cfg_addr   = 8'h00;
    cfg_data   = 2'b11;
    step();
    cfg_we = 1'b0;
    drain();
    send(32'h00000000, 1'b0, 0, 0, 0);
    drain();
    chk("eval_write_ignored", {24'h0, out_data}, 32'h00);

    // Back-to-back throughput.
    stream(5);
    drain();

    // Random tables and random traffic.
    for (int i = 0; i < 4; i++)
      for (int a = 0; a < 256; a++)
        cfg_write(i, a, $urandom_range(0, 3));
    for (int k = 0; k < 12; k++) rand_txn();
    stream(4);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
